// File: rtl/pulse_meter.sv
// pulse_meter: measures high time, low time and period of a sampled pulse waveform,
// counts completed periods and flags inputs that stop toggling.
module pulse_meter #(
    parameter int W           = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         sig_in,
    output logic [W-1:0] high_width,
    output logic [W-1:0] low_width,
    output logic [W-1:0] period,
    output logic [W-1:0] pulse_count,
    output logic         meas_valid,
    output logic         overflow,
    output logic         stuck
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
    localparam logic [W-1:0] MAX = '1;
    localparam logic [W-1:0] TMO = W'(TIMEOUT);
    logic [SYNC_STAGES-1:0] sync;
    logic                   s_d, rise, fall, tmo;
    logic [W-1:0]           hcnt, lcnt, idle;
    logic [W:0]             sum;
    state_t                 state;
    // Edges are registered so the strobe lands SYNC_STAGES+1 posedges after sampling.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync <= '0;
            s_d  <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
            idle <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], sig_in};
            s_d  <= sync[SYNC_STAGES-1];
            rise <= sync[SYNC_STAGES-1] & ~s_d;
            fall <= ~sync[SYNC_STAGES-1] & s_d;
            idle <= (rise | fall) ? '0 : (idle == TMO) ? idle : idle + 1'b1;
        end
    end
    assign sum = {1'b0, hcnt} + {1'b0, lcnt};
    assign tmo = ~rise & ~fall & (idle == TMO - 1'b1);
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            hcnt        <= '0;
            lcnt        <= '0;
            high_width  <= '0;
            low_width   <= '0;
            period      <= '0;
            pulse_count <= '0;
            meas_valid  <= 1'b0;
            overflow    <= 1'b0;
            stuck       <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (rise) stuck <= 1'b0;
            else if (tmo) stuck <= 1'b1;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= HIGH;
                        hcnt  <= W'(1);
                    end
                end
                HIGH: begin
                    if (tmo) begin
                        state <= IDLE;
                        hcnt  <= '0;
                        lcnt  <= '0;
                    end else if (fall) begin
                        state <= LOW;
                        lcnt  <= W'(1);
                    end else if (hcnt != MAX) begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                LOW: begin
                    if (rise) begin
                        high_width  <= hcnt;
                        low_width   <= lcnt;
                        period      <= sum[W] ? MAX : sum[W-1:0];
                        overflow    <= (hcnt == MAX) | (lcnt == MAX) | sum[W];
                        pulse_count <= pulse_count + 1'b1;
                        meas_valid  <= 1'b1;
                        state       <= HIGH;
                        hcnt        <= W'(1);
                        lcnt        <= '0;
                    end else if (tmo) begin
                        state <= IDLE;
                        hcnt  <= '0;
                        lcnt  <= '0;
                    end else if (lcnt != MAX) begin
                        lcnt <= lcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pulse_meter.sv
// tb_pulse_meter: random and directed pulse trains scored against a run-length reference model.
module tb_pulse_meter;
    localparam int W = 4, SS = 2, T = 14, D = SS + 1, MAX = (1 << W) - 1;
    logic clock = 1'b0, reset, sig_in;
    logic [W-1:0] high_width, low_width, period, pulse_count;
    logic meas_valid, overflow, stuck;
    always #5 clock = ~clock;
    pulse_meter #(.W(W), .SYNC_STAGES(SS), .TIMEOUT(T)) dut (
        .clock(clock), .reset(reset), .sig_in(sig_in),
        .high_width(high_width), .low_width(low_width), .period(period),
        .pulse_count(pulse_count), .meas_valid(meas_valid),
        .overflow(overflow), .stuck(stuck)
    );
    typedef struct {int cyc; int h; int l; int p; int c; int o;} exp_t;
    exp_t sb[$];
    logic dl[$];
    int total = 0, bad = 0, cyc = 0;
    int last = 0, rise_t = 0, fall_t = 0, cnt = 0;
    bit armed = 0, fell = 0, prev = 0, m_stuck = 0, m_rst = 1;
    // Reference: the meter sees the input D cycles late; results come from run lengths.
    always @(posedge clock) begin
        logic x;
        exp_t e;
        int hs, ls, s;
        cyc++;
        if (reset) begin
            dl.delete();
            repeat (D) dl.push_back(1'b0);
            prev = 0; last = cyc; armed = 0; fell = 0; cnt = 0; m_stuck = 0; m_rst = 1;
        end else begin
            m_rst = 0;
            dl.push_back(sig_in);
            x = dl.pop_front();
            if (x != prev) begin
                if (x) begin
                    if (armed && fell) begin
                        hs = (fall_t - rise_t > MAX) ? MAX : fall_t - rise_t;
                        ls = (cyc - fall_t > MAX) ? MAX : cyc - fall_t;
                        s = hs + ls;
                        cnt = (cnt + 1) % (MAX + 1);
                        e = '{cyc: cyc, h: hs, l: ls, p: (s > MAX) ? MAX : s, c: cnt,
                              o: int'(hs == MAX || ls == MAX || s > MAX)};
                        sb.push_back(e);
                    end
                    armed = 1; fell = 0; rise_t = cyc; m_stuck = 0;
                end else if (armed) begin
                    fell = 1; fall_t = cyc;
                end
                last = cyc;
            end else if (cyc - last >= T) begin
                m_stuck = 1; armed = 0;
            end
            prev = x;
        end
    end
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask
    always @(negedge clock) begin
        exp_t e;
        if (m_rst) begin
            chk("rst_high_width", int'(high_width), 0);
            chk("rst_low_width", int'(low_width), 0);
            chk("rst_period", int'(period), 0);
            chk("rst_pulse_count", int'(pulse_count), 0);
            chk("rst_meas_valid", int'(meas_valid), 0);
            chk("rst_overflow", int'(overflow), 0);
            chk("rst_stuck", int'(stuck), 0);
        end else begin
            chk("stuck", int'(stuck), int'(m_stuck));
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                chk("meas_valid", int'(meas_valid), 1);
                chk("high_width", int'(high_width), e.h);
                chk("low_width", int'(low_width), e.l);
                chk("period", int'(period), e.p);
                chk("pulse_count", int'(pulse_count), e.c);
                chk("overflow", int'(overflow), e.o);
            end else begin
                chk("meas_valid_idle", int'(meas_valid), 0);
            end
        end
    end
    task automatic step(input logic v);
        sig_in = v;
        @(posedge clock);
        #1;
    endtask
    task automatic run(input logic v, input int n);
        repeat (n) step(v);
    endtask
    task automatic do_reset();
        reset = 1'b1;
        step(sig_in);
        reset = 1'b0;
    endtask
    initial begin
        reset = 1'b1;
        sig_in = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (5) begin run(1, 2); run(0, 3); end
        repeat (6) begin run(1, 1); run(0, 1); end
        run(1, 1); run(0, 3);
        run(1, 20); run(0, 2); run(1, 3); run(0, 13); run(1, 3); run(0, 2);
        do_reset();
        run(0, T + 5); run(1, 3); run(0, 4); run(1, 2); run(0, 2);
        run(1, 4); run(0, 4); run(1, 4); run(0, 2);
        reset = 1'b1; step(0); reset = 1'b0;
        run(0, 2);
        repeat (3) begin run(1, 4); run(0, 4); end
        repeat (200) begin
            run(1, $urandom_range(1, 16));
            run(0, $urandom_range(1, 16));
            if ($urandom_range(0, 40) == 0) do_reset();
        end
        run(0, 6);
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
